ex_mem_hazard_ctrl: RTL and testbench

- Central hazard sequencer for the 5-stage pipeline.
- Watches the EX/MEM pipeline register outputs (branch, jump, zero, memory request) and the ID/EX load state.
- Drives the flush, stall and hold controls into PC, IF/ID, ID/EX and EX/MEM, including the EX_Flush input of the EX/MEM register.
- Sequences multi-cycle data-memory waits with a timeout, and keeps saturating flush/stall statistics.

---
 rtl/ex_mem_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_ex_mem_hazard_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// ex_mem_hazard_ctrl
//
// Central hazard sequencer for the 5-stage pipeline. It looks at the
// EX/MEM pipeline register (branch, jump, zero flag, memory request) and at
// the load sitting in ID/EX. From these it drives the PC/IF-ID write enables,
// the PC source select, the flush controls for IF/ID, ID/EX and EX/MEM, and
// the hold controls for ID/EX and EX/MEM.
//
// Multi-cycle data-memory accesses are sequenced by a two-state FSM
// (RUN / MEM_WAIT). A wait that reaches MEM_TIMEOUT cycles is abandoned and
// recorded in the sticky mem_timeout flag. Saturating counters keep track of
// redirects taken and of stall/hold cycles.
//
// Parameters:
//   MEM_TIMEOUT  maximum held cycles of one access before it is abandoned
//                (1..255)
//   CNT_W        width of the flush/stall statistics counters
//
// Ports:
//   clk               pipeline clock, state updates on the rising edge
//   rst               asynchronous reset, active low (0 = reset)
//   EX_MEM_Branch     branch instruction in MEM stage
//   EX_MEM_ALU_zero   branch condition from EX/MEM
//   EX_MEM_Jump       jump instruction in MEM stage
//   EX_MEM_MemRead    load in MEM stage
//   EX_MEM_MemWrite   store in MEM stage
//   mem_ready         data memory access completes this cycle
//   ID_EX_MemRead     load in EX stage
//   ID_EX_RegisterRt  load destination register
//   IF_ID_RegisterRs  decode source register 1
//   IF_ID_RegisterRt  decode source register 2
//   PCWrite           PC update enable
//   IF_ID_Write       IF/ID update enable
//   PCSrc             00 PC+4, 01 branch target, 10 jump target
//   IF_Flush          clear IF/ID
//   ID_Flush          zero ID/EX control (bubble)
//   EX_Flush          zero EX/MEM control
//   ID_EX_Hold        freeze ID/EX
//   EX_MEM_Hold       freeze EX/MEM
//   mem_timeout       sticky, set when a memory wait was abandoned
//   flush_count       number of redirects taken, saturating
//   stall_count       number of stall/hold cycles, saturating
// ----------------------------------------------------------------------------
module ex_mem_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EX_MEM_Branch,
    input  logic             EX_MEM_ALU_zero,
    input  logic             EX_MEM_Jump,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_MemWrite,
    input  logic             mem_ready,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegisterRt,
    input  logic [4:0]       IF_ID_RegisterRs,
    input  logic [4:0]       IF_ID_RegisterRt,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic [1:0]       PCSrc,
    output logic             IF_Flush,
    output logic             ID_Flush,
    output logic             EX_Flush,
    output logic             ID_EX_Hold,
    output logic             EX_MEM_Hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01
    } state_e;

    localparam logic [7:0]       TIMEOUT_CNT = 8'(MEM_TIMEOUT);
    localparam logic [7:0]       WAIT_ONE    = 8'd1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             mem_timeout_q, mem_timeout_d;

    logic redirect;
    logic mem_req;
    logic load_use;

    // Control values before the reset override is applied.
    logic       pc_write_c;
    logic       if_id_write_c;
    logic [1:0] pc_src_c;
    logic       if_flush_c;
    logic       id_flush_c;
    logic       ex_flush_c;
    logic       id_ex_hold_c;
    logic       ex_mem_hold_c;

    // Event strobes feeding the statistics counters.
    logic       flush_inc;
    logic       stall_inc;

    // Hazard conditions. Register 0 is hard-wired to zero, so a load into it
    // can never create a real dependency.
    always_comb begin
        redirect = (EX_MEM_Branch & EX_MEM_ALU_zero) | EX_MEM_Jump;
        mem_req  = EX_MEM_MemRead | EX_MEM_MemWrite;
        load_use = ID_EX_MemRead
                 & (ID_EX_RegisterRt != 5'd0)
                 & ((ID_EX_RegisterRt == IF_ID_RegisterRs)
                 |  (ID_EX_RegisterRt == IF_ID_RegisterRt));
    end

    // Next-state and control decode. In RUN the hazards are prioritised
    // redirect > memory wait > load-use, because a redirect squashes the
    // instructions that would otherwise cause the lower-priority hazards.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        pc_src_c      = SRC_SEQ;
        if_flush_c    = 1'b0;
        id_flush_c    = 1'b0;
        ex_flush_c    = 1'b0;
        id_ex_hold_c  = 1'b0;
        ex_mem_hold_c = 1'b0;
        flush_inc     = 1'b0;
        stall_inc     = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    if_flush_c = 1'b1;
                    id_flush_c = 1'b1;
                    ex_flush_c = 1'b1;
                    pc_src_c   = EX_MEM_Jump ? SRC_JUMP : SRC_BRANCH;
                    flush_inc  = 1'b1;
                end else if (mem_req && !mem_ready) begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    id_ex_hold_c  = 1'b0 | 1'b1;
                    ex_mem_hold_c = 1'b1;
                    stall_inc     = 1'b1;
                    state_d       = ST_MEM_WAIT;
                    wait_cnt_d    = WAIT_ONE;
                end else if (load_use) begin
                    // The bubble inserted into ID/EX clears the hazard on
                    // the following cycle, so no state is needed here.
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    id_flush_c    = 1'b1;
                    stall_inc     = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                // Redirects and load-use are deliberately ignored while the
                // memory access is outstanding; the whole pipe is frozen.
                if (mem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q >= TIMEOUT_CNT) begin
                    // Abandon the access: release the pipe and record it.
                    state_d       = ST_RUN;
                    wait_cnt_d    = 8'd0;
                    mem_timeout_d = 1'b1;
                end else begin
                    pc_write_c    = 1'b0;
                    if_id_write_c = 1'b0;
                    id_ex_hold_c  = 1'b1;
                    ex_mem_hold_c = 1'b1;
                    stall_inc     = 1'b1;
                    wait_cnt_d    = wait_cnt_q + WAIT_ONE;
                end
            end

            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // Saturating statistics: once a counter reaches all-ones it stays there.
    always_comb begin
        flush_count_d = flush_count_q;
        stall_count_d = stall_count_q;
        if (flush_inc && (flush_count_q != CNT_MAX)) begin
            flush_count_d = flush_count_q + CNT_ONE;
        end
        if (stall_inc && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end
    end

    // State, wait counter, sticky timeout flag and statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
            flush_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            flush_count_q <= flush_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    // While reset is held the pipeline must neither advance nor be flushed,
    // so the controls are forced low directly from the reset input rather
    // than waiting for a clock edge.
    always_comb begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        PCSrc       = SRC_SEQ;
        IF_Flush    = 1'b0;
        ID_Flush    = 1'b0;
        EX_Flush    = 1'b0;
        ID_EX_Hold  = 1'b0;
        EX_MEM_Hold = 1'b0;
        if (rst) begin
            PCWrite     = pc_write_c;
            IF_ID_Write = if_id_write_c;
            PCSrc       = pc_src_c;
            IF_Flush    = if_flush_c;
            ID_Flush    = id_flush_c;
            EX_Flush    = ex_flush_c;
            ID_EX_Hold  = id_ex_hold_c;
            EX_MEM_Hold = ex_mem_hold_c;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign flush_count = flush_count_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_ex_mem_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_hazard_ctrl
//
// Directed testbench for ex_mem_hazard_ctrl built with a short timeout and
// narrow counters so that the timeout and saturation behaviour are reached
// quickly. A behavioural model derives the expected controls and counters
// from the hazard rules every cycle; hand-computed literal checks in the
// stimulus sequence pin the model at the interesting points.
// ----------------------------------------------------------------------------
module tb_ex_mem_hazard_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          EX_MEM_Branch, EX_MEM_ALU_zero, EX_MEM_Jump;
    logic          EX_MEM_MemRead, EX_MEM_MemWrite, mem_ready;
    logic          ID_EX_MemRead;
    logic [4:0]    ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt;
    logic          PCWrite, IF_ID_Write, IF_Flush, ID_Flush, EX_Flush;
    logic          ID_EX_Hold, EX_MEM_Hold, mem_timeout;
    logic [1:0]    PCSrc;
    logic [CW-1:0] flush_count, stall_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    ex_mem_hazard_ctrl #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .EX_MEM_Branch    (EX_MEM_Branch),
        .EX_MEM_ALU_zero  (EX_MEM_ALU_zero),
        .EX_MEM_Jump      (EX_MEM_Jump),
        .EX_MEM_MemRead   (EX_MEM_MemRead),
        .EX_MEM_MemWrite  (EX_MEM_MemWrite),
        .mem_ready        (mem_ready),
        .ID_EX_MemRead    (ID_EX_MemRead),
        .ID_EX_RegisterRt (ID_EX_RegisterRt),
        .IF_ID_RegisterRs (IF_ID_RegisterRs),
        .IF_ID_RegisterRt (IF_ID_RegisterRt),
        .PCWrite          (PCWrite),
        .IF_ID_Write      (IF_ID_Write),
        .PCSrc            (PCSrc),
        .IF_Flush         (IF_Flush),
        .ID_Flush         (ID_Flush),
        .EX_Flush         (EX_Flush),
        .ID_EX_Hold       (ID_EX_Hold),
        .EX_MEM_Hold      (EX_MEM_Hold),
        .mem_timeout      (mem_timeout),
        .flush_count      (flush_count),
        .stall_count      (stall_count)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input int expected);
        n_compared++;
        if (actual !== 32'(expected)) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic br, input logic zero,
                                 input logic jmp, input logic mrd,
                                 input logic mwr, input logic rdy,
                                 input logic idmr, input logic [4:0] idrt,
                                 input logic [4:0] ifrs, input logic [4:0] ifrt);
        EX_MEM_Branch    = br;
        EX_MEM_ALU_zero  = zero;
        EX_MEM_Jump      = jmp;
        EX_MEM_MemRead   = mrd;
        EX_MEM_MemWrite  = mwr;
        mem_ready        = rdy;
        ID_EX_MemRead    = idmr;
        ID_EX_RegisterRt = idrt;
        IF_ID_RegisterRs = ifrs;
        IF_ID_RegisterRt = ifrt;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic memAccess(input logic rdy);
        applyStimulus(0, 0, 0, 1, 0, rdy, 0, 5'd0, 5'd0, 5'd0);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: tracks whether an access is outstanding, how many
    // cycles it has been held so far, and the event totals as plain ints.
    bit m_waiting = 0;
    int m_held    = 0;
    int m_flush   = 0;
    int m_stall   = 0;
    bit m_to      = 0;

    function automatic int satInc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    always begin : model_compare
        bit e_pcw, e_ifw, e_iff, e_idf, e_exf, e_ideh, e_exmh;
        int e_src;
        bit n_waiting, n_to;
        int n_held, n_flush, n_stall;
        bit redirect, mreq, luse;

        @(negedge clk);
        #1;
        if (!rst) begin
            m_waiting = 0; m_held = 0; m_flush = 0; m_stall = 0; m_to = 0;
        end
        n_waiting = m_waiting; n_held = m_held; n_flush = m_flush;
        n_stall = m_stall; n_to = m_to;
        e_pcw = 1; e_ifw = 1; e_src = 0;
        e_iff = 0; e_idf = 0; e_exf = 0; e_ideh = 0; e_exmh = 0;

        redirect = (EX_MEM_Branch && EX_MEM_ALU_zero) || EX_MEM_Jump;
        mreq     = EX_MEM_MemRead || EX_MEM_MemWrite;
        luse     = ID_EX_MemRead && ID_EX_RegisterRt != 0 &&
                   (ID_EX_RegisterRt == IF_ID_RegisterRs ||
                    ID_EX_RegisterRt == IF_ID_RegisterRt);

        if (!rst) begin
            e_pcw = 0; e_ifw = 0;
        end else if (!m_waiting) begin
            if (redirect) begin
                e_iff = 1; e_idf = 1; e_exf = 1;
                e_src = EX_MEM_Jump ? 2 : 1;
                n_flush = satInc(m_flush);
            end else if (mreq && !mem_ready) begin
                e_pcw = 0; e_ifw = 0; e_ideh = 1; e_exmh = 1;
                n_waiting = 1; n_held = 1;
                n_stall = satInc(m_stall);
            end else if (luse) begin
                e_pcw = 0; e_ifw = 0; e_idf = 1;
                n_stall = satInc(m_stall);
            end
        end else begin
            if (mem_ready) begin
                n_waiting = 0; n_held = 0;
            end else if (m_held >= TO) begin
                n_waiting = 0; n_held = 0; n_to = 1;
            end else begin
                e_pcw = 0; e_ifw = 0; e_ideh = 1; e_exmh = 1;
                n_held = m_held + 1;
                n_stall = satInc(m_stall);
            end
        end

        checkOutput("m_PCWrite",     PCWrite,     e_pcw);
        checkOutput("m_IF_ID_Write", IF_ID_Write, e_ifw);
        checkOutput("m_PCSrc",       PCSrc,       e_src);
        checkOutput("m_IF_Flush",    IF_Flush,    e_iff);
        checkOutput("m_ID_Flush",    ID_Flush,    e_idf);
        checkOutput("m_EX_Flush",    EX_Flush,    e_exf);
        checkOutput("m_ID_EX_Hold",  ID_EX_Hold,  e_ideh);
        checkOutput("m_EX_MEM_Hold", EX_MEM_Hold, e_exmh);
        checkOutput("m_mem_timeout", mem_timeout, m_to);
        checkOutput("m_flush_count", flush_count, m_flush);
        checkOutput("m_stall_count", stall_count, m_stall);

        @(posedge clk);
        if (rst) begin
            m_waiting = n_waiting; m_held = n_held; m_flush = n_flush;
            m_stall = n_stall; m_to = n_to;
        end else begin
            m_waiting = 0; m_held = 0; m_flush = 0; m_stall = 0; m_to = 0;
        end
    end

    initial begin
        idle();
        #1 rst = 1'b0;
        repeat (3) begin
            #2;
            checkOutput("rst_PCWrite", PCWrite, 0);
            checkOutput("rst_flush_count", flush_count, 0);
            stepCycle();
        end
        rst = 1'b1;

        // Quiet pipeline
        idle(); #2;
        checkOutput("idle_PCWrite", PCWrite, 1);
        stepCycle();

        // Taken branch
        applyStimulus(1, 1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("br_PCSrc", PCSrc, 1);
        checkOutput("br_IF_Flush", IF_Flush, 1);
        checkOutput("br_EX_Flush", EX_Flush, 1);
        stepCycle();
        idle(); #2;
        checkOutput("br_flush_count", flush_count, 1);
        stepCycle();

        // Not-taken branch
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("nt_IF_Flush", IF_Flush, 0);
        checkOutput("nt_PCSrc", PCSrc, 0);
        stepCycle();

        // Jump + branch + pending load: jump wins, memory request ignored
        applyStimulus(1, 1, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("jb_PCSrc", PCSrc, 2);
        checkOutput("jb_EX_MEM_Hold", EX_MEM_Hold, 0);
        stepCycle();
        idle(); #2;
        checkOutput("jb_still_run", EX_MEM_Hold, 0);
        checkOutput("jb_flush_count", flush_count, 2);
        stepCycle();

        // Load-use on Rs, then the bubble
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd3); #2;
        checkOutput("lu_IF_ID_Write", IF_ID_Write, 0);
        checkOutput("lu_ID_Flush", ID_Flush, 1);
        stepCycle();
        idle(); #2;
        checkOutput("lu_cleared", ID_Flush, 0);
        checkOutput("lu_stall_count", stall_count, 1);
        stepCycle();

        // Load into r0 is never a hazard
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("r0_PCWrite", PCWrite, 1);
        stepCycle();

        // Memory wait: three held cycles, released when ready arrives
        for (int i = 0; i < 3; i++) begin
            memAccess(0); #2;
            checkOutput("mw_hold", EX_MEM_Hold, 1);
            stepCycle();
        end
        memAccess(1); #2;
        checkOutput("mw_release", EX_MEM_Hold, 0);
        checkOutput("mw_release_pcw", PCWrite, 1);
        stepCycle();
        idle(); #2;
        checkOutput("mw_stall_count", stall_count, 4);
        checkOutput("mw_timeout", mem_timeout, 0);
        stepCycle();

        // Ready arrives exactly in the timeout cycle: ready wins
        repeat (4) begin memAccess(0); stepCycle(); end
        memAccess(1); #2;
        checkOutput("rt_release", EX_MEM_Hold, 0);
        stepCycle();
        idle(); #2;
        checkOutput("rt_no_timeout", mem_timeout, 0);
        checkOutput("rt_stall_count", stall_count, 8);
        stepCycle();

        // Timeout: four held cycles, then released and flagged
        for (int i = 0; i < 4; i++) begin
            memAccess(0); #2;
            checkOutput("to_hold", ID_EX_Hold, 1);
            stepCycle();
        end
        memAccess(0); #2;
        checkOutput("to_release", ID_EX_Hold, 0);
        checkOutput("to_release_pcw", PCWrite, 1);
        stepCycle();
        idle(); #2;
        checkOutput("to_flag", mem_timeout, 1);
        checkOutput("to_stall_count", stall_count, 12);
        stepCycle();
        idle(); stepCycle();
        checkOutput("to_sticky", mem_timeout, 1);

        // Drive stall_count into saturation
        repeat (3) begin memAccess(0); stepCycle(); end
        memAccess(1); stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 5'd7, 5'd1, 5'd7); stepCycle();
        idle(); #2;
        checkOutput("sat_stall_count", stall_count, 15);
        stepCycle();

        // Twenty redirects saturate flush_count
        repeat (20) begin
            applyStimulus(0, 0, 1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
            stepCycle();
        end
        idle(); #2;
        checkOutput("sat_flush_count", flush_count, 15);
        stepCycle();

        // Reset dropped in the middle of a memory wait
        memAccess(0); stepCycle();
        memAccess(0); stepCycle();
        #2;
        checkOutput("rw_in_wait", EX_MEM_Hold, 1);
        rst = 1'b0;
        #1;
        checkOutput("rw_hold", EX_MEM_Hold, 0);
        checkOutput("rw_PCWrite", PCWrite, 0);
        checkOutput("rw_stall_count", stall_count, 0);
        checkOutput("rw_flush_count", flush_count, 0);
        checkOutput("rw_timeout", mem_timeout, 0);
        stepCycle();
        idle(); stepCycle();
        rst = 1'b1;
        idle(); #2;
        checkOutput("rw_run_pcw", PCWrite, 1);
        stepCycle();
        memAccess(0); #2;
        checkOutput("rw_new_hold", EX_MEM_Hold, 1);
        stepCycle();
        memAccess(1); stepCycle();
        idle(); #2;
        checkOutput("rw_stall_after", stall_count, 1);
        stepCycle();
        idle(); stepCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule
